// File: rtl/mvm_pkg.sv
// Shared definitions for the serial-weight matrix-vector multiplier:
// default dimensions, FSM state encoding and data/accumulator word types.
package mvm_pkg;

    localparam int MVM_N  = 4;
    localparam int MVM_DW = 4;
    localparam int MVM_AW = 2 * MVM_DW + $clog2(MVM_N);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [MVM_DW-1:0] data_t;
    typedef logic [MVM_AW-1:0] acc_t;

endpackage

// File: rtl/mvm_if.sv
// Bus bundle between the activation/weight source and the mvm block.
// The master drives start, activations and weights; the slave (mvm)
// returns the busy flag and the row results.
interface mvm_if
    import mvm_pkg::*;
#(
    parameter int N  = MVM_N,
    parameter int DW = MVM_DW
);

    logic          i_start_mvm;
    logic [DW-1:0] i_x_bn      [N];
    logic [DW-1:0] i_w_mvm;
    logic          o_ismvm;
    logic [DW-1:0] o_wx_result [N];

    modport master (
        output i_start_mvm,
        output i_x_bn,
        output i_w_mvm,
        input  o_ismvm,
        input  o_wx_result
    );

    modport slave (
        input  i_start_mvm,
        input  i_x_bn,
        input  i_w_mvm,
        output o_ismvm,
        output o_wx_result
    );

endinterface

// File: rtl/mvm_mac.sv
// One unsigned multiply-accumulate lane. The accumulator clears on i_clr
// and adds i_x*i_w when i_en is high. o_acc_nxt is the value the register
// will take at the next edge, so the parent can capture a finished row on
// the same edge the last product is added.
module mvm_mac
    import mvm_pkg::*;
#(
    parameter int DW = MVM_DW,
    parameter int AW = MVM_AW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [DW-1:0] i_x,
    input  logic [DW-1:0] i_w,
    output logic [AW-1:0] o_acc_nxt
);

    logic [AW-1:0]   r_acc;
    logic [2*DW-1:0] w_prod;

    assign w_prod    = {{DW{1'b0}}, i_x} * {{DW{1'b0}}, i_w};
    assign o_acc_nxt = i_en ? (r_acc + AW'(w_prod)) : r_acc;

    // Accumulator register: clear at operation start, add product when enabled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_acc_nxt;
        end
    end

endmodule

// File: rtl/mvm.sv
// Serial-weight matrix-vector multiplier. Latches an N-element activation
// vector on start, consumes N*N weights row-major (one per clock) and
// publishes N row dot products on the edge the last weight is taken.
// Optional macro MVM_SATURATE_EN: saturate results to all-ones instead of
// truncating to the low DW bits.
module mvm
    import mvm_pkg::*;
#(
    parameter int N  = MVM_N,
    parameter int DW = MVM_DW
) (
    input  logic i_clk_mvm,
    input  logic i_rst_mvm,
    mvm_if.slave bus
);

    localparam int AW = 2 * DW + $clog2(N);
    localparam int IW = $clog2(N * N);
    localparam int RW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_x      [N];
    logic [DW-1:0] r_result [N];
    logic [AW-1:0] w_acc_nxt [N];
    logic [RW-1:0] w_row;
    logic [RW-1:0] w_col;
    logic [DW-1:0] w_xsel;
    logic          w_start;
    logic          w_run;
    logic          w_last;

    // Accumulated row sum reduced to an output word.
    function automatic logic [DW-1:0] fmt_result(input logic [AW-1:0] a);
`ifdef MVM_SATURATE_EN
        if (a[AW-1:DW] != '0) begin
            return {DW{1'b1}};
        end
        return a[DW-1:0];
`else
        return a[DW-1:0];
`endif
    endfunction

    // Row/column of the weight currently on i_w_mvm.
    assign w_row  = RW'(r_idx / IW'(N));
    assign w_col  = RW'(r_idx % IW'(N));
    assign w_xsel = r_x[w_col];

    assign bus.o_ismvm = w_run;

    // State register.
    always_ff @(posedge i_clk_mvm or posedge i_rst_mvm) begin
        if (i_rst_mvm) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode; start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_run       = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_start_mvm) begin
                    w_start     = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Weight index and activation capture.
    always_ff @(posedge i_clk_mvm or posedge i_rst_mvm) begin
        if (i_rst_mvm) begin
            r_idx <= '0;
            r_x   <= '{default: '0};
        end else if (w_start) begin
            r_idx <= '0;
            r_x   <= bus.i_x_bn;
        end else if (w_run) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Result register: loaded only when the final weight is consumed.
    always_ff @(posedge i_clk_mvm or posedge i_rst_mvm) begin
        if (i_rst_mvm) begin
            r_result <= '{default: '0};
        end else if (w_last) begin
            for (int i = 0; i < N; i++) begin
                r_result[i] <= fmt_result(w_acc_nxt[i]);
            end
        end
    end

    // One MAC lane per row; only the current row's lane is enabled.
    for (genvar g = 0; g < N; g++) begin : g_lane
        mvm_mac #(
            .DW(DW),
            .AW(AW)
        ) u_mac (
            .i_clk    (i_clk_mvm),
            .i_rst    (i_rst_mvm),
            .i_clr    (w_start),
            .i_en     (w_run && (w_row == RW'(g))),
            .i_x      (w_xsel),
            .i_w      (bus.i_w_mvm),
            .o_acc_nxt(w_acc_nxt[g])
        );
        assign bus.o_wx_result[g] = r_result[g];
    end

endmodule

// File: tb/tb_mvm.sv
// Directed testbench for mvm (N=4, DW=4). Expected results are hand
// computed; the all-8s case depends on MVM_SATURATE_EN.
module tb_mvm;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mvm_if #(.N(4), .DW(4)) bus ();

    mvm #(.N(4), .DW(4)) dut (
        .i_clk_mvm(clk),
        .i_rst_mvm(rst),
        .bus      (bus)
    );

    // Start pulse presented for one edge, returns at the negedge after it.
    task automatic start_op(input logic [3:0] x [4]);
        @(negedge clk);
        bus.i_x_bn      = x;
        bus.i_start_mvm = 1'b1;
        @(negedge clk);
        bus.i_start_mvm = 1'b0;
    endtask

    // Present one weight (and optionally start) for one edge.
    task automatic feed(input logic [3:0] w, input logic st, output logic busy);
        bus.i_w_mvm     = w;
        bus.i_start_mvm = st;
        busy            = bus.o_ismvm;
        @(negedge clk);
        bus.i_start_mvm = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] x [4];
        logic [3:0] w [16];
        logic b;
        rst = 1'b1;
        bus.i_start_mvm = 1'b0;
        bus.i_w_mvm = '0;
        bus.i_x_bn = '{default: '0};
        #12;
        checks++;
        if (bus.o_ismvm !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", bus.o_ismvm);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.o_wx_result[i] !== 4'd0) begin
                errors++;
                $display("FAIL reset_res%0d got %0d want 0", i, bus.o_wx_result[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        // Make results nonzero, then abort a later run mid-cycle.
        x = '{4'd1, 4'd2, 4'd3, 4'd4};
        for (int k = 0; k < 16; k++) w[k] = ((k / 4) == (k % 4)) ? 4'd1 : 4'd0;
        start_op(x);
        for (int k = 0; k < 16; k++) feed(w[k], 1'b0, b);
        start_op(x);
        for (int k = 0; k < 5; k++) feed(w[k], 1'b0, b);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.o_ismvm !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_busy got %b want 0", bus.o_ismvm);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.o_wx_result[i] !== 4'd0) begin
                errors++;
                $display("FAIL async_reset_res%0d got %0d want 0", i, bus.o_wx_result[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_all8();
        logic [3:0] x [4];
        logic [3:0] expv;
        logic b;
        int nbusy = 0;
`ifdef MVM_SATURATE_EN
        expv = 4'd15;
`else
        expv = 4'd0;
`endif
        x = '{4'd8, 4'd8, 4'd8, 4'd8};
        start_op(x);
        for (int k = 0; k < 16; k++) begin
            feed(4'd8, 1'b0, b);
            if (b) nbusy++;
        end
        checks++;
        if (nbusy != 16) begin
            errors++;
            $display("FAIL all8_busy_cycles got %0d want 16", nbusy);
        end
        checks++;
        if (bus.o_ismvm !== 1'b0) begin
            errors++;
            $display("FAIL all8_busy_end got %b want 0", bus.o_ismvm);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.o_wx_result[i] !== expv) begin
                errors++;
                $display("FAIL all8_res%0d got %0d want %0d", i, bus.o_wx_result[i], expv);
            end
        end
    endtask

    task automatic test_identity();
        logic [3:0] x [4];
        logic [3:0] w [16];
        logic [3:0] e [4];
        logic b;
        int nbusy = 0;
        x = '{4'd1, 4'd2, 4'd3, 4'd4};
        e = '{4'd1, 4'd2, 4'd3, 4'd4};
        for (int k = 0; k < 16; k++) w[k] = ((k / 4) == (k % 4)) ? 4'd1 : 4'd0;
        start_op(x);
        for (int k = 0; k < 16; k++) begin
            feed(w[k], 1'b0, b);
            if (b) nbusy++;
        end
        checks++;
        if (nbusy != 16) begin
            errors++;
            $display("FAIL ident_busy_cycles got %0d want 16", nbusy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.o_wx_result[i] !== e[i]) begin
                errors++;
                $display("FAIL ident_res%0d got %0d want %0d", i, bus.o_wx_result[i], e[i]);
            end
        end
    endtask

    task automatic test_row_distinct();
        logic [3:0] x [4];
        logic [3:0] e [4];
        logic b;
        x = '{4'd1, 4'd1, 4'd1, 4'd1};
        e = '{4'd0, 4'd4, 4'd8, 4'd12};
        start_op(x);
        for (int k = 0; k < 16; k++) feed(4'(k / 4), 1'b0, b);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.o_wx_result[i] !== e[i]) begin
                errors++;
                $display("FAIL rowdist_res%0d got %0d want %0d", i, bus.o_wx_result[i], e[i]);
            end
        end
    endtask

    task automatic test_start_during_run();
        logic [3:0] x [4];
        logic [3:0] w [16];
        logic [3:0] e [4];
        logic [3:0] prev [4];
        logic b;
        int nbusy = 0;
        x = '{4'd1, 4'd2, 4'd3, 4'd4};
        w = '{4'd1, 4'd0, 4'd0, 4'd0,
              4'd0, 4'd1, 4'd1, 4'd0,
              4'd1, 4'd1, 4'd1, 4'd1,
              4'd2, 4'd0, 4'd0, 4'd1};
        e = '{4'd1, 4'd5, 4'd10, 4'd6};
        prev = '{4'd0, 4'd4, 4'd8, 4'd12};
        start_op(x);
        // Results must hold across start; activations must not be resampled.
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.o_wx_result[i] !== prev[i]) begin
                errors++;
                $display("FAIL hold_at_start_res%0d got %0d want %0d", i, bus.o_wx_result[i], prev[i]);
            end
        end
        bus.i_x_bn = '{4'd15, 4'd15, 4'd15, 4'd15};
        for (int k = 0; k < 16; k++) begin
            feed(w[k], (k == 4) || (k == 15), b);
            if (b) nbusy++;
        end
        checks++;
        if (nbusy != 16) begin
            errors++;
            $display("FAIL sdr_busy_cycles got %0d want 16", nbusy);
        end
        checks++;
        if (bus.o_ismvm !== 1'b0) begin
            errors++;
            $display("FAIL sdr_busy_end got %b want 0", bus.o_ismvm);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.o_wx_result[i] !== e[i]) begin
                errors++;
                $display("FAIL sdr_res%0d got %0d want %0d", i, bus.o_wx_result[i], e[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.o_ismvm !== 1'b0) begin
            errors++;
            $display("FAIL completion_start_ignored got %b want 0", bus.o_ismvm);
        end
    endtask

    task automatic test_midrun_reset();
        logic [3:0] x [4];
        logic [3:0] w [16];
        logic [3:0] e [4];
        logic b;
        x = '{4'd3, 4'd3, 4'd3, 4'd3};
        start_op(x);
        for (int k = 0; k < 8; k++) feed(4'd5, 1'b0, b);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        x = '{4'd1, 4'd2, 4'd3, 4'd4};
        e = '{4'd1, 4'd2, 4'd3, 4'd4};
        for (int k = 0; k < 16; k++) w[k] = ((k / 4) == (k % 4)) ? 4'd1 : 4'd0;
        start_op(x);
        for (int k = 0; k < 16; k++) feed(w[k], 1'b0, b);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.o_wx_result[i] !== e[i]) begin
                errors++;
                $display("FAIL midrst_res%0d got %0d want %0d", i, bus.o_wx_result[i], e[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all8();
        test_identity();
        test_row_distinct();
        test_start_during_run();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mvm.md
# mvm

Serial-weight matrix-vector multiplier for the neural-network wrapper. It latches an N-element activation vector on a start pulse and streams in an N×N weight matrix one weight per clock, row-major. It accumulates the N dot products and presents them as N result words. It sits between the batch-norm stage (activation source) and the downstream layer logic.

## Interface
Parameters:
- N, 4, vector length and matrix dimension.
- DW, 4, width of each activation, weight and result word.
- AW, 2*DW+$clog2(N), internal accumulator width; derived, not overridden.

Ports:
- i_clk_mvm  in  1  clock; all state on the rising edge.
- i_rst_mvm  in  1  reset, asynchronous, active-high.
- i_start_mvm  in  1  one-cycle start pulse.
- i_x_bn  in  [DW-1:0] ×N (unpacked array)  activation vector from batch-norm.
- i_w_mvm  in  DW  streamed weight, one per cycle.
- o_ismvm  out  1  busy flag; high while weights are being consumed.
- o_wx_result  out  [DW-1:0] ×N (unpacked array)  row results, element i = row i.

Reset is asynchronous and active-high on i_rst_mvm, with a single clock i_clk_mvm.

## Operation
- All arithmetic is unsigned. Products are 2*DW bits. Accumulators are AW bits and cannot overflow.
- States are IDLE and RUN.
- **IDLE, i_start_mvm=1:**
  - capture i_x_bn into an internal vector register;
  - clear all accumulators and the index counter;
  - go to RUN.
- **RUN, each cycle:**
  - sample i_w_mvm as W[r][c], where r = idx/N and c = idx%N;
  - add W[r][c]*x[c] to acc[r];
  - increment idx.
- **End of RUN:** after N*N weights (idx = N*N-1 consumed), return to IDLE and load o_wx_result[i] from acc[i] (see Configuration).
- i_start_mvm during RUN is ignored. i_x_bn is not sampled during RUN.
- o_wx_result holds its value until the next completion or reset; it does not change at start.
- **Reset (including mid-RUN):** state=IDLE, idx=0, accumulators=0, x register=0, o_wx_result all 0, o_ismvm=0. The partial result is discarded.

## Timing
- Start sampled at edge T0. Weights are sampled at edges T1..T(N*N), i.e. T1..T16 for N=4.
- o_ismvm rises after T0 and falls after T(N*N).
- o_wx_result is updated at the same edge where o_ismvm falls.
- Latency from the start edge to valid result is N*N edges (16).
- A start asserted on the edge where RUN ends is ignored. A new start is accepted from the following cycle.
- Back-to-back operations therefore have a throughput of one matrix per N*N+1 cycles.

## Configuration
- Macro: MVM_SATURATE_EN.
- **Defined:** o_wx_result[i] = min(acc[i], 2^DW-1), i.e. saturate to all-ones.
- **Undefined:** o_wx_result[i] = acc[i][DW-1:0], i.e. truncation/wrap.

## Structure
- Package mvm_pkg holds:
  - the default N and DW;
  - the state enum {IDLE, RUN};
  - typedefs for the data word and the accumulator.
- Sub-module mvm_mac: one multiply-accumulate lane (clear, enable, x, w → acc).
- The top module instantiates N mvm_mac lanes. Only lane r (the current row) is enabled in a given cycle.
- The counter, FSM and output register stay in the top module.

## Test plan
- **Reset:** assert i_rst_mvm asynchronously mid-cycle → o_ismvm=0 and all results 0 immediately.
- **All-8s:** x all 8, w held at 8, one start pulse.
  - o_ismvm is high for 16 cycles.
  - Each acc = 256. With MVM_SATURATE_EN, results are 15 (4'b1111). Without it, results are 0.
- **Identity:** x={1,2,3,4}; weights streamed as the identity matrix → results {1,2,3,4} after 16 cycles, in both configurations.
- **Row-distinct:** x all 1; row r weights all equal to r → results {0,4,8,12}.
- **Start during RUN:** pulse start at cycle 5 of RUN → ignored; completion still at edge 16 with correct results. A start on the completion edge is also ignored.
- **Mid-run reset:** assert reset at weight 8, then run identity with x={1,2,3,4} → results {1,2,3,4}, with no residue from the aborted run.
